// File: rtl/stack_ctrl_pkg.sv
// Shared types and encodings for the LIFO stack sequencing controller.
package stack_ctrl_pkg;

    localparam int STK_DW    = 4;
    localparam int STK_DEPTH = 16;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    localparam logic REQ_CU = 1'b0;
    localparam logic REQ_DU = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        PUSH,
        POP_DEC,
        POP_RD,
        RESP
    } state_e;

endpackage

// File: rtl/stack_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the requester not granted last wins a tie.
module rr_arb2
    import stack_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt,
    output logic       gnt_id
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_id = REQ_CU;
        if (req[REQ_DU] && (!req[REQ_CU] || last_q == REQ_CU)) begin
            gnt_id = REQ_DU;
        end
        gnt    = {(|req) & gnt_id, (|req) & ~gnt_id};
        last_d = accept ? gnt_id : last_q;
    end

    // Reset as if DU was served last so CU wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= REQ_DU;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/stack_ctrl.sv
// Stack sequencing controller: arbitrates CU/DU access to the LIFO stack.
// Optional saturating error counter output under STACK_CTRL_ERR_CNT_EN.
module stack_ctrl
    import stack_ctrl_pkg::*;
#(
    parameter int DW    = STK_DW,
    parameter int DEPTH = STK_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
`ifdef STACK_CTRL_ERR_CNT_EN
    output logic [7:0]    err_cnt,
`endif
    input  logic          flush,
    input  logic          cu_req_valid,
    input  logic          cu_req_op,
    input  logic [DW-1:0] cu_req_data,
    output logic          cu_req_ready,
    output logic          cu_rsp_valid,
    output logic          cu_rsp_err,
    output logic [DW-1:0] cu_rsp_data,
    input  logic          du_req_valid,
    input  logic          du_req_op,
    input  logic [DW-1:0] du_req_data,
    output logic          du_req_ready,
    output logic          du_rsp_valid,
    output logic          du_rsp_err,
    output logic [DW-1:0] du_rsp_data,
    output logic          stk_reset,
    output logic          stk_push,
    output logic          stk_pop,
    output logic          stk_we,
    output logic          stk_re,
    output logic          stk_mux_sel,
    output logic [DW-1:0] stk_data_1_in,
    output logic [DW-1:0] stk_data_2_in,
    input  logic [DW-1:0] stk_data_out,
    input  logic          stk_full,
    input  logic          stk_empty
);

    // DEPTH only has to agree with the external stack's full flag.
    if (DEPTH < 1) begin : g_depth_unused
    end

    state_e        state_q, state_d;
    logic          id_q, id_d;
    logic [DW-1:0] du_data_q, du_data_d;
    logic [DW-1:0] cu_data_q, cu_data_d;
    logic          cu_err_q, cu_err_d;
    logic          du_err_q, du_err_d;
    logic [DW-1:0] cu_rdata_q, cu_rdata_d;
    logic [DW-1:0] du_rdata_q, du_rdata_d;

    logic          accept;
    logic          gnt_id;
    logic [1:0]    gnt;
    logic          req_op;
    logic          rsp_err;
    logic [DW-1:0] rsp_data;

    assign accept = (state_q == IDLE) && !flush
                  && (cu_req_valid || du_req_valid);

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({du_req_valid, cu_req_valid}),
        .accept (accept),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        du_data_d  = du_data_q;
        cu_data_d  = cu_data_q;
        cu_err_d   = cu_err_q;
        du_err_d   = du_err_q;
        cu_rdata_d = cu_rdata_q;
        du_rdata_d = du_rdata_q;
        rsp_err    = 1'b0;
        rsp_data   = '0;
        req_op     = (gnt_id == REQ_DU) ? du_req_op : cu_req_op;

        unique case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = FLUSH;
                end else if (accept) begin
                    id_d = gnt_id;
                    if (gnt_id == REQ_DU) du_data_d = du_req_data;
                    else                  cu_data_d = cu_req_data;
                    if (req_op == OP_PUSH) state_d = stk_full  ? RESP : PUSH;
                    else                   state_d = stk_empty ? RESP : POP_DEC;
                    // Only reaches the response when the op is refused.
                    rsp_err = 1'b1;
                end
            end
            FLUSH:   state_d = IDLE;
            PUSH:    state_d = RESP;
            POP_DEC: state_d = POP_RD;
            POP_RD: begin
                state_d  = RESP;
                rsp_data = stk_data_out;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_q != RESP && state_d == RESP) begin
            if (id_d == REQ_DU) begin
                du_err_d   = rsp_err;
                du_rdata_d = rsp_data;
            end else begin
                cu_err_d   = rsp_err;
                cu_rdata_d = rsp_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            id_q       <= REQ_CU;
            du_data_q  <= '0;
            cu_data_q  <= '0;
            cu_err_q   <= 1'b0;
            du_err_q   <= 1'b0;
            cu_rdata_q <= '0;
            du_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            du_data_q  <= du_data_d;
            cu_data_q  <= cu_data_d;
            cu_err_q   <= cu_err_d;
            du_err_q   <= du_err_d;
            cu_rdata_q <= cu_rdata_d;
            du_rdata_q <= du_rdata_d;
        end
    end

    assign stk_reset     = rst | (state_q == FLUSH);
    assign stk_push      = (state_q == PUSH);
    assign stk_we        = (state_q == PUSH);
    assign stk_mux_sel   = (state_q == PUSH) && (id_q == REQ_DU);
    assign stk_pop       = (state_q == POP_DEC);
    assign stk_re        = (state_q == POP_RD);
    assign stk_data_1_in = du_data_q;
    assign stk_data_2_in = cu_data_q;

    assign cu_req_ready  = accept & gnt[REQ_CU];
    assign du_req_ready  = accept & gnt[REQ_DU];
    assign cu_rsp_valid  = (state_q == RESP) && (id_q == REQ_CU);
    assign du_rsp_valid  = (state_q == RESP) && (id_q == REQ_DU);
    assign cu_rsp_err    = cu_err_q;
    assign du_rsp_err    = du_err_q;
    assign cu_rsp_data   = cu_rdata_q;
    assign du_rsp_data   = du_rdata_q;

`ifdef STACK_CTRL_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       rsp_is_err;

    assign rsp_is_err = (id_q == REQ_DU) ? du_err_q : cu_err_q;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (state_q == FLUSH) begin
            err_cnt_d = '0;
        end else if (state_q == RESP && rsp_is_err && err_cnt_q != 8'hff) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_stack_ctrl.sv
// Randomized bench for stack_ctrl against a transaction-level stack model.
module tb_stack_ctrl;
    import stack_ctrl_pkg::*;

    localparam int K_PUSH  = 0;
    localparam int K_POP   = 1;
    localparam int K_ERR   = 2;
    localparam int K_FLUSH = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       cu_req_valid = 1'b0, cu_req_op = 1'b0;
    logic [3:0] cu_req_data = '0;
    logic       cu_req_ready, cu_rsp_valid, cu_rsp_err;
    logic [3:0] cu_rsp_data;
    logic       du_req_valid = 1'b0, du_req_op = 1'b0;
    logic [3:0] du_req_data = '0;
    logic       du_req_ready, du_rsp_valid, du_rsp_err;
    logic [3:0] du_rsp_data;
    logic       stk_reset, stk_push, stk_pop, stk_we, stk_re, stk_mux_sel;
    logic [3:0] stk_data_1_in, stk_data_2_in, stk_data_out;
    logic       stk_full, stk_empty;
`ifdef STACK_CTRL_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    always #5 clk = ~clk;

    stack_ctrl #(.DW(4), .DEPTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
`ifdef STACK_CTRL_ERR_CNT_EN
        .err_cnt       (err_cnt),
`endif
        .flush         (flush),
        .cu_req_valid  (cu_req_valid),
        .cu_req_op     (cu_req_op),
        .cu_req_data   (cu_req_data),
        .cu_req_ready  (cu_req_ready),
        .cu_rsp_valid  (cu_rsp_valid),
        .cu_rsp_err    (cu_rsp_err),
        .cu_rsp_data   (cu_rsp_data),
        .du_req_valid  (du_req_valid),
        .du_req_op     (du_req_op),
        .du_req_data   (du_req_data),
        .du_req_ready  (du_req_ready),
        .du_rsp_valid  (du_rsp_valid),
        .du_rsp_err    (du_rsp_err),
        .du_rsp_data   (du_rsp_data),
        .stk_reset     (stk_reset),
        .stk_push      (stk_push),
        .stk_pop       (stk_pop),
        .stk_we        (stk_we),
        .stk_re        (stk_re),
        .stk_mux_sel   (stk_mux_sel),
        .stk_data_1_in (stk_data_1_in),
        .stk_data_2_in (stk_data_2_in),
        .stk_data_out  (stk_data_out),
        .stk_full      (stk_full),
        .stk_empty     (stk_empty)
    );

    // Stack datapath: pointer plus RAM, driven only by the strobes.
    logic [3:0] mem [0:16];
    int         sp = 0;

    always @(posedge clk) begin
        if (stk_reset) begin
            sp <= 0;
        end else if (stk_push && stk_we) begin
            if (sp < 16) begin
                mem[sp] <= stk_mux_sel ? stk_data_1_in : stk_data_2_in;
                sp      <= sp + 1;
            end
        end else if (stk_pop && sp > 0) begin
            sp <= sp - 1;
        end
    end

    assign stk_full     = (sp == 16);
    assign stk_empty    = (sp == 0);
    assign stk_data_out = stk_re ? mem[sp] : 4'h0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state.
    logic [3:0] ref_q [$];
    bit         busy = 0;
    int         kind = 0;
    int         age  = 0;
    int         lat  = 0;
    bit         who  = 0;
    logic [3:0] exp_data = '0;
    bit         last = 1;
    bit         cu_pend = 0, du_pend = 0;
    bit         cu_op = 0, du_op = 0;
    logic [3:0] cu_d = '0, du_d = '0;
    bit         flush_req = 0;
    bit         rst_pop = 0;
    int         accepts = 0;
    int         errc = 0;

    task automatic step();
        bit         do_rst, was_busy, w, op;
        logic [4:0] es;
        logic [1:0] er, ev;
        logic [3:0] d;
        @(negedge clk);
        if (busy) age++;
        do_rst = rst_pop && busy && kind == K_POP && age == 2;
        rst          = do_rst;
        flush        = flush_req;
        cu_req_valid = cu_pend;
        cu_req_op    = cu_op;
        cu_req_data  = cu_d;
        du_req_valid = du_pend;
        du_req_op    = du_op;
        du_req_data  = du_d;
        #1;
`ifdef STACK_CTRL_ERR_CNT_EN
        check("err_cnt", 32'(err_cnt), 32'(errc));
`endif
        if (do_rst) begin
            check("rst_stk_reset", 32'(stk_reset), 32'(1));
            check("rst_rsp_valid", 32'({du_rsp_valid, cu_rsp_valid}), 32'(0));
            busy = 0;
            rst_pop = 0;
            ref_q.delete();
            last = 1;
            errc = 0;
            return;
        end
        was_busy = busy;
        es = '0;
        er = '0;
        ev = '0;
        w  = (cu_pend && du_pend) ? ~last : du_pend;
        if (was_busy) begin
            case (kind)
                K_FLUSH: es = 5'b10000;
                K_PUSH:  if (age == 1) es = 5'b01010;
                K_POP: begin
                    if (age == 1) es = 5'b00100;
                    if (age == 2) es = 5'b00001;
                end
                default: es = 5'b00000;
            endcase
            if (age == lat && kind != K_FLUSH) ev[who] = 1'b1;
        end else if (!flush_req && (cu_pend || du_pend)) begin
            er[w] = 1'b1;
        end
        check("ready", 32'({du_req_ready, cu_req_ready}), 32'(er));
        check("strobes", 32'({stk_reset, stk_push, stk_pop, stk_we, stk_re}),
              32'(es));
        if (es[3]) check("mux_sel", 32'(stk_mux_sel), 32'(who));
        check("rsp_valid", 32'({du_rsp_valid, cu_rsp_valid}), 32'(ev));
        if (ev != 0) begin
            check("rsp_err", 32'(who ? du_rsp_err : cu_rsp_err),
                  32'(kind == K_ERR));
            check("rsp_data", 32'(who ? du_rsp_data : cu_rsp_data),
                  32'(kind == K_POP ? exp_data : 4'h0));
            if (kind == K_ERR && errc < 255) errc++;
        end
        if (was_busy) begin
            if (kind == K_FLUSH) errc = 0;
            if (age == lat) busy = 0;
        end else if (flush_req) begin
            flush_req = 0;
            busy = 1; kind = K_FLUSH; lat = 1; age = 0;
            ref_q.delete();
        end else if (cu_pend || du_pend) begin
            op = w ? du_op : cu_op;
            d  = w ? du_d : cu_d;
            last = w;
            if (w) du_pend = 0;
            else   cu_pend = 0;
            busy = 1; age = 0; who = w;
            accepts++;
            if (op == OP_PUSH) begin
                if (ref_q.size() < 16) begin
                    ref_q.push_back(d);
                    kind = K_PUSH; lat = 2;
                end else begin
                    kind = K_ERR; lat = 1;
                end
            end else if (ref_q.size() > 0) begin
                exp_data = ref_q.pop_back();
                kind = K_POP; lat = 3;
            end else begin
                kind = K_ERR; lat = 1;
            end
        end
    endtask

    task automatic drain(input int max);
        int n = 0;
        while ((busy || cu_pend || du_pend || flush_req) && n < max) begin
            step();
            n++;
        end
        check("drain_timeout", 32'(busy || cu_pend || du_pend || flush_req),
              32'(0));
    endtask

    task automatic req(input bit r, input bit op, input logic [3:0] d);
        if (r) begin du_pend = 1; du_op = op; du_d = d; end
        else   begin cu_pend = 1; cu_op = op; cu_d = d; end
    endtask

    task automatic both_phase(input bit op);
        int a0 = accepts;
        int g  = 0;
        while (accepts - a0 < 8 && g < 200) begin
            if (!cu_pend) req(REQ_CU, op, 4'h1);
            if (!du_pend) req(REQ_DU, op, 4'h2);
            step();
            g++;
        end
        check("both_accepts", 32'(accepts - a0), 32'(8));
        cu_pend = 0;
        du_pend = 0;
        drain(20);
    endtask

    initial begin
        repeat (2) begin
            @(negedge clk);
            #1;
            check("reset_stk_reset", 32'(stk_reset), 32'(1));
            check("reset_strobes",
                  32'({stk_push, stk_pop, stk_we, stk_re, stk_mux_sel}), 32'(0));
            check("reset_outputs",
                  32'({cu_req_ready, du_req_ready, cu_rsp_valid, du_rsp_valid,
                       cu_rsp_err, du_rsp_err, cu_rsp_data, du_rsp_data}), 32'(0));
        end

        req(REQ_CU, OP_PUSH, 4'hA); drain(20);
        req(REQ_CU, OP_POP, 4'h0);  drain(20);
        req(REQ_DU, OP_PUSH, 4'h5); drain(20);
        req(REQ_DU, OP_POP, 4'h0);  drain(20);
        step();
        check("empty_after_pop", 32'(stk_empty), 32'(1));
        req(REQ_CU, OP_POP, 4'h0);  drain(20);

        for (int i = 0; i < 17; i++) begin
            req(REQ_DU, OP_PUSH, 4'($urandom));
            drain(20);
        end
        step();
        check("full_after_17", 32'(stk_full), 32'(ref_q.size() == 16));
        for (int i = 0; i < 16; i++) begin
            req(1'($urandom), OP_POP, 4'h0);
            drain(20);
        end

        both_phase(OP_PUSH);
        both_phase(OP_POP);

        for (int i = 0; i < 3; i++) begin
            req(REQ_CU, OP_PUSH, 4'(i + 3));
            drain(20);
        end
        flush_req = 1;
        drain(20);
        step();
        check("empty_after_flush", 32'(stk_empty), 32'(1));
        req(REQ_CU, OP_POP, 4'h0); drain(20);

        for (int i = 0; i < 400; i++) begin
            if (!cu_pend && $urandom_range(0, 2) == 0)
                req(REQ_CU, $urandom_range(0, 9) >= 6, 4'($urandom));
            if (!du_pend && $urandom_range(0, 2) == 0)
                req(REQ_DU, $urandom_range(0, 9) >= 6, 4'($urandom));
            if (!flush_req && $urandom_range(0, 49) == 0) flush_req = 1;
            step();
        end
        drain(50);

        req(REQ_CU, OP_PUSH, 4'h7); drain(20);
        req(REQ_DU, OP_POP, 4'h0);
        rst_pop = 1;
        drain(20);
        check("rst_pop_consumed", 32'(rst_pop), 32'(0));
        req(REQ_CU, OP_POP, 4'h0); drain(20);
        step();
        check("empty_after_rst", 32'(stk_empty), 32'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
